game_state_fsm: RTL and testbench
=================================

GAME_STATE_FSM -- requirements
Module: game_state_fsm

Interface
- REQ-001 NUM_KEYS, 2, number of simultaneous keycode slots examined (1..6).
- REQ-002 KEY_W, 8, width of one keycode slot.
- REQ-003 STATE_W, 8, width of the state output bus.
- REQ-004 START_KEY, 40, keycode that starts or restarts play (Enter).
- REQ-005 ESC_KEY, 41, keycode that aborts to title (Esc).
- REQ-006 PAUSE_KEY, 19, keycode that toggles pause ('P').
- REQ-007 OVER_HOLD, 120, frame ticks spent in OVER before automatic return to TITLE (must be at least 1).
- REQ-008 Clk  in  1  system clock; all state changes on its rising edge.
- REQ-009 Reset  in  1  asynchronous, active-high reset.
- REQ-010 frame_tick  in  1  one-Clk pulse per video frame.
- REQ-011 keycode  in  NUM_KEYS*KEY_W  packed keycode slots; slot i is bits [i*KEY_W +: KEY_W]; 0 means empty.
- REQ-012 player_dead  in  1  level from collision logic: the player fell off screen.
- REQ-013 state  out  STATE_W  current state, zero-extended: TITLE=0, PLAY=1, PAUSE=2, OVER=3.
- REQ-014 state_changed  out  1  one-Clk pulse in the cycle after any state transition.
- REQ-015 frame_count  out  16  frames elapsed in PLAY during the current run.

Function
- REQ-016 A key is present when any slot equals its code; key value 0 never matches.
- REQ-017 Press event = key present this cycle and not present the previous cycle (registered per key); holding a key yields exactly one event.
- REQ-018 Event priority within one cycle: ESC press > player_dead > START press > PAUSE press; only the highest applicable event acts.
- REQ-019 TITLE: START press -> PLAY; all other inputs ignored.
- REQ-020 PLAY: ESC press -> TITLE; player_dead=1 -> OVER; PAUSE press -> PAUSE.
- REQ-021 PAUSE: ESC press -> TITLE; PAUSE or START press -> PLAY; player_dead ignored.
- REQ-022 OVER: ESC press -> TITLE; START press -> PLAY; otherwise the state returns to TITLE on the frame_tick that completes OVER_HOLD ticks counted since entry.
- REQ-023 The OVER hold counter clears on every entry to OVER and counts only while in OVER.
- REQ-024 state is registered: it shows the new value one Clk after the cycle in which the event is sampled.
- REQ-025 state_changed is high for exactly the first cycle in which state shows a new value.
- REQ-026 frame_count clears to 0 on a transition into PLAY from TITLE or OVER.
- REQ-027 frame_count holds on a transition from PAUSE to PLAY.
- REQ-028 frame_count increments on frame_tick only while the registered state is PLAY, and saturates at 16'hFFFF.
- REQ-029 frame_count holds its value in PAUSE and OVER, and clears when TITLE is entered.

Reset
- REQ-030 Reset=1 forces, asynchronously: state=TITLE, state_changed=0, frame_count=0, hold counter=0, all previous-presence registers=0.
- REQ-031 Reset asserted mid-run abandons the run; after release, the FSM needs a fresh START press.
- REQ-032 A key held across reset release is treated as newly pressed.

Configuration
- REQ-033 Macro GAME_STATE_PAUSE_EN defined: PAUSE state and PAUSE_KEY handling are present, as specified above.
- REQ-034 Macro GAME_STATE_PAUSE_EN undefined: no PAUSE state is built, PAUSE_KEY is ignored, state never takes the value 2, and all other behaviour is unchanged.

Verification
- REQ-035 Reset, then keycode={0,40} for 1 cycle -> state=1 one Clk later, state_changed pulses once, frame_count=0.
- REQ-036 In PLAY, hold keycode slot0=40 for 50 cycles with 3 frame_ticks -> state stays 1 (no re-trigger), frame_count=3.
- REQ-037 In PLAY, press ESC and assert player_dead in the same cycle -> state=0, not 3.
- REQ-038 In PLAY, player_dead=1 -> state=3; with OVER_HOLD=4 and 4 frame_ticks -> state=0 after the 4th tick; repeat with a START press after 2 ticks -> state=1, frame_count=0.
- REQ-039 (PAUSE_EN) Press 19 in PLAY with frame_count=5, apply 10 frame_ticks, press 19 again -> state 1->2->1, frame_count stays 5; (no PAUSE_EN) same stimulus -> state stays 1, frame_count=15.
- REQ-040 Assert Reset asynchronously in OVER between clock edges -> state=0 and frame_count=0 immediately; a held key 40 at release -> state=1 one Clk after release.

Source files
------------

// File: rtl/game_state_fsm_if.sv
// game_state_fsm_if: groups the game-state FSM's frame, key and status signals.
//   master : frame/key/collision source; it observes state, state_changed and frame_count
//   slave  : game_state_fsm
// Signals:
//   frame_tick    one-clock pulse per video frame
//   keycode       NUM_KEYS packed keycode slots, slot i = [i*KEY_W +: KEY_W], 0 = empty
//   player_dead   level, the player fell off screen
//   state         current state, zero-extended (TITLE=0 PLAY=1 PAUSE=2 OVER=3)
//   state_changed one-clock pulse in the first cycle state shows a new value
//   frame_count   frames elapsed in PLAY during the current run
interface game_state_fsm_if #(
  parameter int NUM_KEYS = 2,
  parameter int KEY_W    = 8,
  parameter int STATE_W  = 8
);
  logic                      frame_tick;
  logic [NUM_KEYS*KEY_W-1:0] keycode;
  logic                      player_dead;
  logic [STATE_W-1:0]        state;
  logic                      state_changed;
  logic [15:0]               frame_count;

  modport master (output frame_tick, keycode, player_dead,
                  input  state, state_changed, frame_count);
  modport slave  (input  frame_tick, keycode, player_dead,
                  output state, state_changed, frame_count);
endinterface

// File: rtl/game_state_fsm.sv
// game_state_fsm: TITLE / PLAY / PAUSE / OVER game flow controller.
// Ports:
//   clk  system clock, all state changes on its rising edge
//   rst  asynchronous active-high reset
//   bus  game_state_fsm_if.slave (frame_tick, keycode, player_dead in;
//        state, state_changed, frame_count out)
// Build option: define GAME_STATE_PAUSE_EN to build the PAUSE state and
// PAUSE_KEY handling; without it PAUSE_KEY is ignored and state never reads 2.
// Key presses are edge-detected per key, so a held key yields one event;
// presence registers clear on reset, so a key held across release counts as
// a fresh press.
module game_state_fsm #(
  parameter int NUM_KEYS  = 2,
  parameter int KEY_W     = 8,
  parameter int STATE_W   = 8,
  parameter int START_KEY = 40,
  parameter int ESC_KEY   = 41,
  parameter int PAUSE_KEY = 19,
  parameter int OVER_HOLD = 120
) (
  input logic               clk,
  input logic               rst,
  game_state_fsm_if.slave   bus
);
  localparam int HW = (OVER_HOLD > 1) ? $clog2(OVER_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(OVER_HOLD - 1);

`ifdef GAME_STATE_PAUSE_EN
  typedef enum logic [1:0] {TITLE = 2'd0, PLAY = 2'd1, PAUSE = 2'd2, OVER = 2'd3} state_t;
`else
  typedef enum logic [1:0] {TITLE = 2'd0, PLAY = 2'd1, OVER = 2'd3} state_t;
`endif

  state_t          state_q, state_d;
  logic            changed_q;
  logic [15:0]     fc_q;
  logic [HW-1:0]   hold_q;

  // per-slot key matches; an empty slot (0) never matches
  logic [NUM_KEYS-1:0] hit_start, hit_esc;
  logic start_now, esc_now, start_prev, esc_prev, start_ev, esc_ev;
`ifdef GAME_STATE_PAUSE_EN
  logic [NUM_KEYS-1:0] hit_pause;
  logic pause_now, pause_prev, pause_ev;
`endif

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_slot
    logic [KEY_W-1:0] k;
    assign k            = bus.keycode[i*KEY_W +: KEY_W];
    assign hit_start[i] = (k != '0) && (k == KEY_W'(START_KEY));
    assign hit_esc[i]   = (k != '0) && (k == KEY_W'(ESC_KEY));
`ifdef GAME_STATE_PAUSE_EN
    assign hit_pause[i] = (k != '0) && (k == KEY_W'(PAUSE_KEY));
`endif
  end

  assign start_now = |hit_start;
  assign esc_now   = |hit_esc;
  assign start_ev  = start_now & ~start_prev;
  assign esc_ev    = esc_now & ~esc_prev;
`ifdef GAME_STATE_PAUSE_EN
  assign pause_now = |hit_pause;
  assign pause_ev  = pause_now & ~pause_prev;
`endif

  // Priority ESC > dead > START > PAUSE, applied only among the events a
  // state reacts to (e.g. dead is not applicable in OVER or PAUSE).
  always_comb begin
    state_d = state_q;
    case (state_q)
      TITLE: if (start_ev) state_d = PLAY;
      PLAY: begin
        if (esc_ev)               state_d = TITLE;
        else if (bus.player_dead) state_d = OVER;
`ifdef GAME_STATE_PAUSE_EN
        else if (pause_ev)        state_d = PAUSE;
`endif
      end
`ifdef GAME_STATE_PAUSE_EN
      PAUSE: begin
        if (esc_ev)                    state_d = TITLE;
        else if (start_ev || pause_ev) state_d = PLAY;
      end
`endif
      OVER: begin
        if (esc_ev)                                  state_d = TITLE;
        else if (start_ev)                           state_d = PLAY;
        else if (bus.frame_tick && hold_q == HOLD_LAST) state_d = TITLE;
      end
      default: state_d = TITLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= TITLE;
      changed_q  <= 1'b0;
      fc_q       <= '0;
      hold_q     <= '0;
      start_prev <= 1'b0;
      esc_prev   <= 1'b0;
`ifdef GAME_STATE_PAUSE_EN
      pause_prev <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      changed_q  <= (state_d != state_q);
      start_prev <= start_now;
      esc_prev   <= esc_now;
`ifdef GAME_STATE_PAUSE_EN
      pause_prev <= pause_now;
`endif
      // hold counter only runs while staying in OVER; any entry sees it at 0
      if (state_q == OVER && state_d == OVER) begin
        if (bus.frame_tick) hold_q <= hold_q + 1'b1;
      end else begin
        hold_q <= '0;
      end
      // a fresh run (from TITLE/OVER) or TITLE entry clears; resuming from
      // PAUSE keeps the count; ticks count on the registered PLAY state
      if (state_d == TITLE)
        fc_q <= '0;
      else if (state_d == PLAY && (state_q == TITLE || state_q == OVER))
        fc_q <= '0;
      else if (state_q == PLAY && bus.frame_tick && fc_q != 16'hFFFF)
        fc_q <= fc_q + 16'd1;
    end
  end

  assign bus.state         = STATE_W'(state_q);
  assign bus.state_changed = changed_q;
  assign bus.frame_count   = fc_q;
endmodule

// File: tb/tb_game_state_fsm.sv
// Testbench for game_state_fsm: directed scenarios plus randomized stimulus
// compared each cycle against a behavioural model of the game flow rules.
module tb_game_state_fsm;
  localparam int NK = 2, KW = 8, SW = 8, HOLD = 4;
`ifdef GAME_STATE_PAUSE_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  game_state_fsm_if #(.NUM_KEYS(NK), .KEY_W(KW), .STATE_W(SW)) bus ();

  game_state_fsm #(.NUM_KEYS(NK), .KEY_W(KW), .STATE_W(SW), .START_KEY(40),
                   .ESC_KEY(41), .PAUSE_KEY(19), .OVER_HOLD(HOLD))
    dut (.clk(clk), .rst(rst), .bus(bus.slave));

  int n_chk = 0, n_pass = 0;

  // behavioural model: 0=TITLE 1=PLAY 2=PAUSE 3=OVER
  int m_state, m_fc, m_hold;
  bit m_chg, m_ps, m_pe, m_pp;

  function automatic bit has_key(input logic [NK*KW-1:0] kc, input int code);
    bit r = 0;
    for (int i = 0; i < NK; i++)
      if (kc[i*KW +: KW] != 0 && int'(kc[i*KW +: KW]) == code) r = 1;
    return r;
  endfunction

  task automatic model_reset();
    m_state = 0; m_fc = 0; m_hold = 0; m_chg = 0; m_ps = 0; m_pe = 0; m_pp = 0;
  endtask

  task automatic model_step();
    bit ps, pe, pp, se, ee, pev, ft;
    int nx;
    ps = has_key(bus.keycode, 40); pe = has_key(bus.keycode, 41);
    pp = PEN && has_key(bus.keycode, 19);
    se = ps && !m_ps; ee = pe && !m_pe; pev = pp && !m_pp;
    ft = bus.frame_tick;
    nx = m_state;
    if (m_state == 0) begin
      if (se) nx = 1;
    end else if (m_state == 1) begin
      if (ee) nx = 0; else if (bus.player_dead) nx = 3; else if (pev) nx = 2;
    end else if (m_state == 2) begin
      if (ee) nx = 0; else if (se || pev) nx = 1;
    end else begin
      if (ee) nx = 0; else if (se) nx = 1; else if (ft && m_hold + 1 >= HOLD) nx = 0;
    end
    if (nx == 0) m_fc = 0;
    else if (nx == 1 && (m_state == 0 || m_state == 3)) m_fc = 0;
    else if (m_state == 1 && ft && m_fc < 65535) m_fc++;
    m_hold = (nx == 3 && m_state == 3) ? m_hold + int'(ft) : 0;
    m_chg = (nx != m_state);
    m_state = nx;
    m_ps = ps; m_pe = pe; m_pp = pp;
  endtask

  // advance one clock; DUT sampled 1ns after the edge
  task automatic cyc();
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    #1;
  endtask

  task automatic set_in(input int k0, input int k1, input bit dead, input bit ft);
    bus.keycode     = {k1[KW-1:0], k0[KW-1:0]};
    bus.player_dead = dead;
    bus.frame_tick  = ft;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bus.frame_tick = 1'b1; cyc(); bus.frame_tick = 1'b0; cyc();
    end
  endtask

  task automatic test_reset();
    set_in(0, 0, 0, 0);
    rst = 1'b1;
    repeat (3) cyc();
    n_chk++;
    if ({bus.state, bus.state_changed, bus.frame_count} !== {8'd0, 1'b0, 16'd0})
      $display("FAIL reset_hold: got st=%0d chg=%0d fc=%0d want 0/0/0", bus.state, bus.state_changed, bus.frame_count);
    else n_pass++;
    rst = 1'b0;
    repeat (2) cyc();
    n_chk++;
    if ({bus.state, bus.state_changed, bus.frame_count} !== {8'd0, 1'b0, 16'd0})
      $display("FAIL reset_idle: got st=%0d chg=%0d fc=%0d want 0/0/0", bus.state, bus.state_changed, bus.frame_count);
    else n_pass++;
  endtask

  task automatic test_start();
    set_in(40, 0, 0, 0); cyc(); set_in(0, 0, 0, 0);
    n_chk++;
    if ({bus.state, bus.state_changed, bus.frame_count} !== {8'd1, 1'b1, 16'd0})
      $display("FAIL start: got st=%0d chg=%0d fc=%0d want 1/1/0", bus.state, bus.state_changed, bus.frame_count);
    else n_pass++;
    cyc();
    n_chk++;
    if ({bus.state, bus.state_changed} !== {8'd1, 1'b0})
      $display("FAIL start_pulse: got st=%0d chg=%0d want 1/0", bus.state, bus.state_changed);
    else n_pass++;
  endtask

  task automatic test_hold_start();
    int changes = 0;
    for (int i = 0; i < 50; i++) begin
      set_in(40, 0, 0, (i == 10 || i == 20 || i == 30));
      cyc();
      changes += int'(bus.state_changed);
    end
    set_in(0, 0, 0, 0);
    n_chk++;
    if ({bus.state, bus.frame_count} !== {8'd1, 16'd3} || changes != 0)
      $display("FAIL hold_start: got st=%0d fc=%0d changes=%0d want 1/3/0", bus.state, bus.frame_count, changes);
    else n_pass++;
  endtask

  task automatic test_esc_dead();
    set_in(0, 41, 1, 0); cyc(); set_in(0, 0, 0, 0);
    n_chk++;
    if ({bus.state, bus.state_changed, bus.frame_count} !== {8'd0, 1'b1, 16'd0})
      $display("FAIL esc_over_dead: got st=%0d chg=%0d fc=%0d want 0/1/0", bus.state, bus.state_changed, bus.frame_count);
    else n_pass++;
  endtask

  task automatic test_over();
    set_in(40, 0, 0, 0); cyc(); set_in(0, 0, 0, 0); cyc();
    ticks(2);
    bus.player_dead = 1'b1; cyc(); bus.player_dead = 1'b0;
    n_chk++;
    if ({bus.state, bus.state_changed, bus.frame_count} !== {8'd3, 1'b1, 16'd2})
      $display("FAIL enter_over: got st=%0d chg=%0d fc=%0d want 3/1/2", bus.state, bus.state_changed, bus.frame_count);
    else n_pass++;
    ticks(3);
    n_chk++;
    if ({bus.state, bus.frame_count} !== {8'd3, 16'd2})
      $display("FAIL over_3ticks: got st=%0d fc=%0d want 3/2", bus.state, bus.frame_count);
    else n_pass++;
    bus.frame_tick = 1'b1; cyc(); bus.frame_tick = 1'b0;
    n_chk++;
    if ({bus.state, bus.state_changed, bus.frame_count} !== {8'd0, 1'b1, 16'd0})
      $display("FAIL over_timeout: got st=%0d chg=%0d fc=%0d want 0/1/0", bus.state, bus.state_changed, bus.frame_count);
    else n_pass++;
    // second run: restart from OVER after 2 ticks
    set_in(40, 0, 0, 0); cyc(); set_in(0, 0, 0, 0); cyc();
    ticks(3);
    bus.player_dead = 1'b1; cyc(); bus.player_dead = 1'b0;
    ticks(2);
    set_in(0, 40, 0, 0); cyc(); set_in(0, 0, 0, 0);
    n_chk++;
    if ({bus.state, bus.state_changed, bus.frame_count} !== {8'd1, 1'b1, 16'd0})
      $display("FAIL over_restart: got st=%0d chg=%0d fc=%0d want 1/1/0", bus.state, bus.state_changed, bus.frame_count);
    else n_pass++;
  endtask

  task automatic test_pause();
    ticks(5);
    set_in(19, 0, 0, 0); cyc(); set_in(0, 0, 0, 0);
    n_chk++;
    if (bus.state !== (PEN ? 8'd2 : 8'd1))
      $display("FAIL pause_enter: got st=%0d want %0d", bus.state, PEN ? 2 : 1);
    else n_pass++;
    ticks(10);
    set_in(19, 0, 0, 0); cyc(); set_in(0, 0, 0, 0);
    n_chk++;
    if ({bus.state, bus.frame_count} !== {8'd1, (PEN ? 16'd5 : 16'd15)})
      $display("FAIL pause_resume: got st=%0d fc=%0d want 1/%0d", bus.state, bus.frame_count, PEN ? 5 : 15);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    bus.player_dead = 1'b1; cyc(); bus.player_dead = 1'b0;
    ticks(1);
    #2 rst = 1'b1; model_reset();
    #1;
    n_chk++;
    if ({bus.state, bus.state_changed, bus.frame_count} !== {8'd0, 1'b0, 16'd0})
      $display("FAIL async_reset: got st=%0d chg=%0d fc=%0d want 0/0/0", bus.state, bus.state_changed, bus.frame_count);
    else n_pass++;
    set_in(40, 0, 0, 0);
    cyc();
    #2 rst = 1'b0;
    cyc();
    set_in(0, 0, 0, 0);
    n_chk++;
    if ({bus.state, bus.state_changed} !== {8'd1, 1'b1})
      $display("FAIL held_key_release: got st=%0d chg=%0d want 1/1", bus.state, bus.state_changed);
    else n_pass++;
  endtask

  function automatic int pick_key();
    int r = int'($urandom_range(0, 9));
    if (r < 4) return 0;
    if (r < 6) return 40;
    if (r == 6) return 41;
    if (r < 9) return 19;
    return int'($urandom_range(1, 255));
  endfunction

  task automatic test_random();
    int k0 = 0, k1 = 0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) < 4) k0 = pick_key();
      if ($urandom_range(0, 9) < 2) k1 = pick_key();
      set_in(k0, k1, ($urandom_range(0, 11) == 0), ($urandom_range(0, 2) == 0));
      rst = ($urandom_range(0, 299) == 0);
      cyc();
      n_chk++;
      if ({bus.state, bus.state_changed, bus.frame_count} !== {8'(m_state), m_chg, 16'(m_fc)})
        $display("FAIL random[%0d]: got st=%0d chg=%0d fc=%0d want %0d/%0d/%0d", i,
                 bus.state, bus.state_changed, bus.frame_count, m_state, m_chg, m_fc);
      else n_pass++;
    end
    rst = 1'b0;
    set_in(0, 0, 0, 0);
  endtask

  initial begin
    model_reset();
    set_in(0, 0, 0, 0);
    test_reset();
    test_start();
    test_hold_start();
    test_esc_dead();
    test_over();
    test_pause();
    test_async_reset();
    rst = 1'b1; cyc(); rst = 1'b0; cyc();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
